btm_trunc_div: RTL and testbench
================================

// Module: btm_trunc_div
// PURPOSE
// - Sequential truncated divider; inverse companion of the truncated multiplier.
// - Drops the NAB LSBs of both operands and divides the truncated values by
//   radix-2 restoring iteration, one quotient bit per clock.
// - Sits in the same datapath as the multiplier; returns an approximate a/b
//   plus remainder through a start/done handshake.
// PARAMETERS
// - BWOP  default 10  operand and result bit width
// - NAB   default 0   number of truncated LSBs per operand; 0 <= NAB < BWOP
// PORTS
// - clk    in   1     clock; all state updates on rising edge
// - rst_n  in   1     asynchronous active-low reset
// - start  in   1     request; sampled only in IDLE or DONE
// - a      in   BWOP  dividend; sampled on the accepted start edge
// - b      in   BWOP  divisor; sampled on the accepted start edge
// - busy   out  1     high while an operation is in progress (RUN)
// - done   out  1     one-cycle pulse when c/r/div0 are updated
// - c      out  BWOP  quotient of truncated operands, zero-extended
// - r      out  BWOP  remainder of truncated operands, shifted left by NAB
// - div0   out  1     last operation had truncated divisor == 0
// BEHAVIOUR
// - Interface: one clock, clk; asynchronous active-low reset, rst_n.
// - Reset: async assert forces IDLE; busy, done, c, r, div0 = 0; counter = 0.
//   Reset mid-operation aborts; no done is produced for that operation.
// - Definitions: N = BWOP-NAB; at = a[BWOP-1:NAB]; bt = b[BWOP-1:NAB].
// - States: IDLE -> (start & bt!=0) RUN; IDLE -> (start & bt==0) DONE;
//   RUN -> DONE after N iterations; DONE -> IDLE, or directly to RUN/DONE if
//   start is high in DONE (back-to-back, no bubble).
// - start while busy is ignored; a/b are not re-sampled during RUN.
// - RUN iteration k (k = N-1 down to 0): rem = {rem, at[k]}; if rem >= bt then
//   rem -= bt and q[k] = 1, else q[k] = 0. rem is N+1 bits internally.
// - Latency: start edge + N RUN edges; done = 1, busy = 0 in the cycle after
//   the final RUN edge. start-to-done = N+1 edges. busy = 1 exactly N cycles.
// - Results: c = {NAB'b0, q}; r = {rem[N-1:0], NAB'b0}; div0 = 0.
//   c, r, div0 hold their value until the next done; never change mid-RUN.
// - Divide by zero (bt == 0): no iteration; done one edge after start;
//   c = all ones (BWOP bits), r = {at, NAB'b0}, div0 = 1.
// - at == 0: normal path, full N iterations, c = 0, r = 0.
// CONFIGURATION
// - BTM_DIV_ROUND_EN defined: on the final RUN edge, if 2*rem >= bt then
//   q = q+1, saturating at all ones. r always reports the unrounded
//   remainder. Latency unchanged. div0 path unaffected.
// - BTM_DIV_ROUND_EN undefined: quotient is truncated (floor) only.
// TESTING
// - BWOP=10,NAB=0: a=1000,b=7,start 1 cycle -> busy 10 cycles, done at edge 11,
//   c=142, r=6, div0=0; with BTM_DIV_ROUND_EN c=143, r=6.
// - BWOP=10,NAB=2: a=1000,b=40 -> at=250,bt=10; done at edge 9, c=25, r=0.
// - BWOP=10,NAB=2: a=1000,b=3 -> bt=0; done 1 edge after start, c=10'h3FF,
//   r=1000, div0=1; next op a=9,b=9 clears div0 (c=1, r=0).
// - start pulsed at cycles 3..6 of a running op -> ignored; single done,
//   result of first operands only.
// - start held high in DONE with new a=100,b=10 (NAB=0) -> no IDLE cycle;
//   second done 11 edges later with c=10, r=0.
// - rst_n low at RUN cycle 4 -> outputs 0 immediately; no done; a fresh start
//   after release completes normally.

Source files
------------

// File: rtl/btm_trunc_div.sv
// btm_trunc_div: sequential truncated divider, companion of the truncated
// multiplier. The NAB LSBs of both operands are dropped and the truncated
// values are divided by radix-2 restoring iteration, one quotient bit per
// clock, behind a start/done handshake.
// Optional feature: define BTM_DIV_ROUND_EN to round the quotient to nearest
// on the final iteration (remainder output stays unrounded).
module btm_trunc_div #(
  parameter int BWOP = 10,
  parameter int NAB  = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [BWOP-1:0] a,
  input  logic [BWOP-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [BWOP-1:0] c,
  output logic [BWOP-1:0] r,
  output logic            div0
);

  localparam int N  = BWOP - NAB;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [N-1:0]    at_q,    at_d;
  logic [N-1:0]    bt_q,    bt_d;
  logic [N:0]      rem_q,   rem_d;
  logic [N-1:0]    quo_q,   quo_d;
  logic [BWOP-1:0] c_q,     c_d;
  logic [BWOP-1:0] r_q,     r_d;
  logic            div0_q,  div0_d;

  logic [N-1:0]    a_t;
  logic [N-1:0]    b_t;
  logic            accept;
  logic [N:0]      rem_sh;
  logic            fits;
  logic [N:0]      rem_nx;
  logic [N-1:0]    quo_nx;
  logic [N-1:0]    quo_fin;

  assign a_t = a[BWOP-1:NAB];
  assign b_t = b[BWOP-1:NAB];

  // start is honoured in IDLE and DONE only; ignored while iterating
  assign accept = start && (state_q != S_RUN);

  // One restoring step: the dividend register is shifted left so its MSB is
  // always the next bit at[k], avoiding a variable index into at.
  always_comb begin
    rem_sh = {rem_q[N-1:0], at_q[N-1]};
    fits   = (rem_sh >= {1'b0, bt_q});
    rem_nx = fits ? (rem_sh - {1'b0, bt_q}) : rem_sh;
    quo_nx = N'((quo_q << 1) | N'(fits));
  end

`ifdef BTM_DIV_ROUND_EN
  logic rnd_up;

  // Round-to-nearest on the last step: bump q when 2*rem >= bt, saturating
  always_comb begin
    rnd_up  = ({rem_nx, 1'b0} >= {2'b00, bt_q});
    quo_fin = quo_nx;
    if (rnd_up && (quo_nx != '1)) begin
      quo_fin = quo_nx + N'(1);
    end
  end
`else
  // Truncated (floor) quotient only
  always_comb begin
    quo_fin = quo_nx;
  end
`endif

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    at_d    = at_q;
    bt_d    = bt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    c_d     = c_q;
    r_d     = r_q;
    div0_d  = div0_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          at_d  = a_t;
          bt_d  = b_t;
          rem_d = '0;
          quo_d = '0;
          cnt_d = CW'(N - 1);
          if (b_t == '0) begin
            // divide by zero resolves on the start edge, no iteration
            state_d = S_DONE;
            c_d     = '1;
            r_d     = BWOP'(a_t) << NAB;
            div0_d  = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        at_d  = at_q << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          // results are published only on the final step
          state_d = S_DONE;
          c_d     = BWOP'(quo_fin);
          r_d     = BWOP'(rem_nx[N-1:0]) << NAB;
          div0_d  = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      at_q    <= '0;
      bt_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      c_q     <= '0;
      r_q     <= '0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      at_q    <= at_d;
      bt_q    <= bt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      c_q     <= c_d;
      r_q     <= r_d;
      div0_q  <= div0_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign c    = c_q;
  assign r    = r_q;
  assign div0 = div0_q;

endmodule

// File: tb/tb_btm_trunc_div.sv
// Bench for btm_trunc_div: two instances (NAB=0 and NAB=2, BWOP=10) driven
// from a vector table and hand-written corner sequences; expected results
// are queued at start and checked whenever done is seen.
module tb_btm_trunc_div;

  logic            clk;
  logic            rst_n;
  logic [1:0]      start_v;
  logic [1:0][9:0] a_v;
  logic [1:0][9:0] b_v;
  logic [1:0]      busy_v;
  logic [1:0]      done_v;
  logic [1:0][9:0] c_v;
  logic [1:0][9:0] r_v;
  logic [1:0]      div0_v;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  typedef struct {
    logic [9:0] c;
    logic [9:0] r;
    logic       d0;
    int         lat;
    int         start_edge;
    string      name;
  } exp_t;

  typedef struct {
    int         u;
    logic [9:0] a;
    logic [9:0] b;
    logic [9:0] c;
    logic [9:0] r;
    logic       d0;
    string      name;
  } vec_t;

  exp_t sb0[$];
  exp_t sb1[$];
  exp_t e0, e1;
  vec_t tbl[16];

  btm_trunc_div #(.BWOP(10), .NAB(0)) u_n0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .c(c_v[0]), .r(r_v[0]), .div0(div0_v[0])
  );

  btm_trunc_div #(.BWOP(10), .NAB(2)) u_n2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .c(c_v[1]), .r(r_v[1]), .div0(div0_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic unexp(input int u);
    compared++;
    mismatched++;
    $display("FAIL unexpected_done_u%0d: got done=1, required no done", u);
  endtask

  task automatic check_out(input int u, input exp_t e);
    chk({e.name, "_c"},    int'(c_v[u]),    int'(e.c));
    chk({e.name, "_r"},    int'(r_v[u]),    int'(e.r));
    chk({e.name, "_div0"}, int'(div0_v[u]), int'(e.d0));
    chk({e.name, "_lat"},  cyc - e.start_edge, e.lat);
  endtask

  // Scoreboard pop on every done pulse
  always @(negedge clk) begin
    if (rst_n && done_v[0]) begin
      if (sb0.size() == 0) unexp(0);
      else begin
        e0 = sb0.pop_front();
        check_out(0, e0);
      end
    end
    if (rst_n && done_v[1]) begin
      if (sb1.size() == 0) unexp(1);
      else begin
        e1 = sb1.pop_front();
        check_out(1, e1);
      end
    end
  end

  // Builds the expected record; rounding adjusts c only on the normal path
  function automatic exp_t mk(input int u, input logic [9:0] b, input logic [9:0] c,
                              input logic [9:0] r, input logic d0, input string nm);
    exp_t e;
    int nab;
    int bt;
    int rem;
    nab = (u == 0) ? 0 : 2;
    bt  = int'(b) >> nab;
    rem = int'(r) >> nab;
    e.c = c;
`ifdef BTM_DIV_ROUND_EN
    if (!d0 && (2 * rem >= bt)) e.c = c + 10'd1;
`endif
    e.r          = r;
    e.d0         = d0;
    e.lat        = d0 ? 0 : ((u == 0) ? 10 : 8);
    e.start_edge = cyc + 1;
    e.name       = nm;
    return e;
  endfunction

  task automatic start_op(input int u, input logic [9:0] a, input logic [9:0] b,
                          input logic [9:0] c, input logic [9:0] r, input logic d0,
                          input bit push, input bit sync, input string nm);
    if (sync) @(negedge clk);
    a_v[u]     = a;
    b_v[u]     = b;
    start_v[u] = 1'b1;
    if (push) begin
      if (u == 0) sb0.push_back(mk(u, b, c, r, d0, nm));
      else        sb1.push_back(mk(u, b, c, r, d0, nm));
    end
    @(negedge clk);
    start_v[u] = 1'b0;
  endtask

  task automatic wait_done(input int u, input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done_v[u]) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({nm, "_done_seen"}, int'(seen), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bcnt;
    bit seen;

    tbl[0]  = '{0, 10'd1000, 10'd7,    10'd142,  10'd6,   1'b0, "t_1000_7"};
    tbl[1]  = '{1, 10'd1000, 10'd40,   10'd25,   10'd0,   1'b0, "t2_1000_40"};
    tbl[2]  = '{1, 10'd1000, 10'd3,    10'h3FF,  10'd1000, 1'b1, "t2_div0"};
    tbl[3]  = '{1, 10'd9,    10'd9,    10'd1,    10'd0,   1'b0, "t2_9_9"};
    tbl[4]  = '{0, 10'd0,    10'd5,    10'd0,    10'd0,   1'b0, "t_0_5"};
    tbl[5]  = '{0, 10'd1023, 10'd1,    10'd1023, 10'd0,   1'b0, "t_1023_1"};
    tbl[6]  = '{0, 10'd5,    10'd1023, 10'd0,    10'd5,   1'b0, "t_5_1023"};
    tbl[7]  = '{0, 10'd1023, 10'd1023, 10'd1,    10'd0,   1'b0, "t_1023_1023"};
    tbl[8]  = '{0, 10'd0,    10'd0,    10'h3FF,  10'd0,   1'b1, "t_div0_zero"};
    tbl[9]  = '{0, 10'd777,  10'd25,   10'd31,   10'd2,   1'b0, "t_777_25"};
    tbl[10] = '{0, 10'd500,  10'd3,    10'd166,  10'd2,   1'b0, "t_500_3"};
    tbl[11] = '{1, 10'd1023, 10'd7,    10'd255,  10'd0,   1'b0, "t2_1023_7"};
    tbl[12] = '{1, 10'd1023, 10'd12,   10'd85,   10'd0,   1'b0, "t2_1023_12"};
    tbl[13] = '{1, 10'd800,  10'd44,   10'd18,   10'd8,   1'b0, "t2_800_44"};
    tbl[14] = '{1, 10'd3,    10'd400,  10'd0,    10'd0,   1'b0, "t2_3_400"};
    tbl[15] = '{0, 10'd1023, 10'd2,    10'd511,  10'd1,   1'b0, "t_1023_2"};

    rst_n   = 1'b0;
    start_v = '0;
    a_v     = '0;
    b_v     = '0;
    #1;
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("rst_busy_u%0d", u), int'(busy_v[u]), 0);
      chk($sformatf("rst_done_u%0d", u), int'(done_v[u]), 0);
      chk($sformatf("rst_c_u%0d", u),    int'(c_v[u]),    0);
      chk($sformatf("rst_r_u%0d", u),    int'(r_v[u]),    0);
      chk($sformatf("rst_div0_u%0d", u), int'(div0_v[u]), 0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // busy must last exactly N cycles for the reference operation
    start_op(0, 10'd1000, 10'd7, 10'd142, 10'd6, 1'b0, 1'b1, 1'b1, "busy_ref");
    bcnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done_v[0]) begin
        seen = 1'b1;
        break;
      end
      if (busy_v[0]) bcnt++;
      @(negedge clk);
    end
    chk("busy_ref_done_seen", int'(seen), 1);
    chk("busy_ref_busy_cycles", bcnt, 10);
    chk("busy_ref_busy_low_at_done", int'(busy_v[0]), 0);

    // Table-driven vectors
    for (int i = 0; i < 16; i++) begin
      start_op(tbl[i].u, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].r, tbl[i].d0,
               1'b1, 1'b1, tbl[i].name);
      wait_done(tbl[i].u, tbl[i].name);
    end

    // start pulsed during RUN cycles 3..6 is ignored; outputs hold mid-RUN
    start_op(0, 10'd100, 10'd9, 10'd11, 10'd1, 1'b0, 1'b1, 1'b1, "ign");
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      a_v[0]     = 10'd55;
      b_v[0]     = 10'd3;
      start_v[0] = 1'b1;
      @(negedge clk);
    end
    start_v[0] = 1'b0;
    chk("ign_c_hold_midrun", int'(c_v[0]), 511
`ifdef BTM_DIV_ROUND_EN
        + 1
`endif
    );
    chk("ign_busy_midrun", int'(busy_v[0]), 1);
    wait_done(0, "ign");
    repeat (15) @(negedge clk);
    chk("ign_sb_empty", sb0.size(), 0);

    // back-to-back: start held in DONE, no IDLE bubble
    start_op(0, 10'd1000, 10'd7, 10'd142, 10'd6, 1'b0, 1'b1, 1'b1, "b2b_1");
    wait_done(0, "b2b_1");
    start_op(0, 10'd100, 10'd10, 10'd10, 10'd0, 1'b0, 1'b1, 1'b0, "b2b_2");
    chk("b2b_no_bubble_busy", int'(busy_v[0]), 1);
    wait_done(0, "b2b_2");

    // reset mid-RUN aborts with no done; fresh op afterwards completes
    start_op(0, 10'd1000, 10'd7, 10'd0, 10'd0, 1'b0, 1'b0, 1'b1, "abort");
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy_v[0]), 0);
    chk("abort_done", int'(done_v[0]), 0);
    chk("abort_c",    int'(c_v[0]),    0);
    chk("abort_r",    int'(r_v[0]),    0);
    chk("abort_div0", int'(div0_v[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    start_op(0, 10'd100, 10'd10, 10'd10, 10'd0, 1'b0, 1'b1, 1'b1, "after_rst");
    wait_done(0, "after_rst");
    repeat (3) @(negedge clk);
    chk("final_sb0_empty", sb0.size(), 0);
    chk("final_sb1_empty", sb1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
